// File: rtl/mips_pkg.sv
// Shared fetch-stage definitions: reset vector, bubble encoding and fetch FSM states.
package mips_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_INST         = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } fetch_state_t;

    // Instruction addresses are word aligned; low two bits are always dropped.
    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_pc_reg.sv
// Program counter with priority reset > redirect > increment > hold.
module if_pc_reg
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        incr,
    output logic [31:0] pc
);

    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (redirect) begin
            pc <= align_pc(redirect_pc);
        end else if (incr) begin
            pc <= pc + 32'd4;
        end
    end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch: one outstanding imem request, one-entry return buffer feeding IF/ID.
// Handshake: a request is accepted in the cycle Imem_Req & Imem_Ack; its data returns with Imem_Rvalid in a later cycle.
module if_fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Stall,
    input  logic        Redirect_Valid,
    input  logic [31:0] Redirect_PC,
    output logic        Imem_Req,
    output logic [31:0] Imem_Addr,
    input  logic        Imem_Ack,
    input  logic [31:0] Imem_Rdata,
    input  logic        Imem_Rvalid,
    output logic [31:0] PC_4,
    output logic [31:0] Inst,
    output logic        IF_Flush,
    output logic        IF_stall,
    output logic [1:0]  dbg_state,
    output logic        dbg_buf_valid
);

    fetch_state_t state;
    logic [31:0]  pc;
    logic [31:0]  req_pc4;
    logic [31:0]  buf_inst;
    logic [31:0]  buf_pc4;
    logic         buf_valid;
    logic         consume;
    logic         accept;

    assign consume  = buf_valid & ~Stall & ~Redirect_Valid;
    assign Imem_Req = (state == ST_REQ) & (~buf_valid | consume) & ~Redirect_Valid;
    assign accept   = Imem_Req & Imem_Ack;

    assign Imem_Addr     = pc;
    assign Inst          = buf_inst;
    assign PC_4          = buf_pc4;
    assign IF_Flush      = Redirect_Valid | (~buf_valid & ~Stall);
    assign IF_stall      = Stall & ~Redirect_Valid;
    assign dbg_state     = state;
    assign dbg_buf_valid = buf_valid;

    if_pc_reg #(.RESET_PC(RESET_PC)) u_pc (
        .clk         (Clk),
        .rst         (Rst),
        .redirect    (Redirect_Valid),
        .redirect_pc (Redirect_PC),
        .incr        (accept),
        .pc          (pc)
    );

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state     <= ST_REQ;
            req_pc4   <= 32'h0;
            buf_inst  <= NOP_INST;
            buf_pc4   <= 32'h0;
            buf_valid <= 1'b0;
        end else begin
            if (consume) begin
                buf_valid <= 1'b0;
            end
            case (state)
                ST_REQ: begin
                    if (Redirect_Valid) begin
                        buf_valid <= 1'b0;
                    end else if (accept) begin
                        req_pc4 <= pc + 32'd4;
                        state   <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // The buffer is empty here, so a landing word never collides with a held one.
                    if (Redirect_Valid) begin
                        buf_valid <= 1'b0;
                        state     <= Imem_Rvalid ? ST_REQ : ST_DROP;
                    end else if (Imem_Rvalid) begin
                        buf_inst  <= Imem_Rdata;
                        buf_pc4   <= req_pc4;
                        buf_valid <= 1'b1;
                        state     <= ST_REQ;
                    end
                end
                ST_DROP: begin
                    if (Redirect_Valid) begin
                        buf_valid <= 1'b0;
                    end
                    if (Imem_Rvalid) begin
                        state <= ST_REQ;
                    end
                end
                default: state <= ST_REQ;
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed vector table, reset-vector wrap sequence and randomized run against a transaction model.
module tb_if_fetch_stage;
    import mips_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, stall, rdir, ack, rv;
    logic [31:0] rpc, rdata;
    logic        req, flush, istall, bv;
    logic [31:0] addr, inst, pc4;
    logic [1:0]  st;
    logic        req2, flush2, istall2, bv2;
    logic [31:0] addr2, inst2, pc42;
    logic [1:0]  st2;

    int n_checks = 0;
    int n_fail   = 0;

    if_fetch_stage dut (
        .Clk(clk), .Rst(rst), .Stall(stall), .Redirect_Valid(rdir), .Redirect_PC(rpc),
        .Imem_Req(req), .Imem_Addr(addr), .Imem_Ack(ack), .Imem_Rdata(rdata),
        .Imem_Rvalid(rv), .PC_4(pc4), .Inst(inst), .IF_Flush(flush), .IF_stall(istall),
        .dbg_state(st), .dbg_buf_valid(bv)
    );

    if_fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .Clk(clk), .Rst(rst), .Stall(stall), .Redirect_Valid(rdir), .Redirect_PC(rpc),
        .Imem_Req(req2), .Imem_Addr(addr2), .Imem_Ack(ack), .Imem_Rdata(rdata),
        .Imem_Rvalid(rv), .PC_4(pc42), .Inst(inst2), .IF_Flush(flush2), .IF_stall(istall2),
        .dbg_state(st2), .dbg_buf_valid(bv2)
    );

    typedef struct {
        logic rst, stall, rdir;
        logic [31:0] rpc;
        logic ack, rv;
        logic [31:0] rdata;
        logic chk, req;
        logic [31:0] addr, inst, pc4;
        logic flush, istall, bv;
        logic [1:0] st;
    } vec_t;

    vec_t tbl[19];

    function automatic vec_t v(input logic r, s, d, input logic [31:0] p, input logic a, rvl,
                               input logic [31:0] dt, input logic c, q, input logic [31:0] ad,
                               input logic [31:0] in, pc, input logic f, is, b, input logic [1:0] sv);
        vec_t t;
        t.rst = r; t.stall = s; t.rdir = d; t.rpc = p; t.ack = a; t.rv = rvl; t.rdata = dt;
        t.chk = c; t.req = q; t.addr = ad; t.inst = in; t.pc4 = pc;
        t.flush = f; t.istall = is; t.bv = b; t.st = sv;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input logic r, s, d, input logic [31:0] p, input logic a, vl,
                         input logic [31:0] dt);
        rst = r; stall = s; rdir = d; rpc = p; ack = a; rv = vl; rdata = dt;
    endtask

    // Transaction-level model: an outstanding flag, a kill flag for redirected
    // requests, and a single-slot holding buffer.
    logic [31:0] m_pc, m_inst, m_pc4, m_pend;
    logic        m_busy, m_kill, m_full;
    logic        e_req, e_flush, e_istall, e_cons;

    task automatic model_reset(input logic [31:0] rv_pc);
        m_pc = rv_pc; m_busy = 0; m_kill = 0; m_full = 0;
        m_inst = 32'h0; m_pc4 = 32'h0; m_pend = 32'h0;
    endtask

    task automatic model_outputs(input logic s, d);
        e_cons   = m_full && !s && !d;
        e_req    = !m_busy && (!m_full || e_cons) && !d;
        e_flush  = d || (!m_full && !s);
        e_istall = s && !d;
    endtask

    task automatic model_edge(input logic r, s, d, input logic [31:0] p, input logic a, vl,
                              input logic [31:0] dt);
        model_outputs(s, d);
        if (r) begin
            model_reset(32'h0);
        end else if (d) begin
            m_full = 0;
            m_pc   = p & ~32'h3;
            if (m_busy && vl) begin
                m_busy = 0;
                m_kill = 0;
            end else if (m_busy) begin
                m_kill = 1;
            end
        end else begin
            if (e_cons) m_full = 0;
            if (m_busy && vl) begin
                if (!m_kill) begin
                    m_full = 1; m_inst = dt; m_pc4 = m_pend;
                end
                m_kill = 0;
                m_busy = 0;
            end else if (e_req && a) begin
                m_pend = m_pc + 32'd4;
                m_pc   = m_pc + 32'd4;
                m_busy = 1;
            end
        end
    endtask

    logic        mem_pend;
    int          mem_cnt;
    logic [31:0] mem_data;

    initial begin
        logic r, s, d, a, vl, req_seen;
        logic [31:0] p, dt;

        tbl[0]  = v(1,0,0,32'h0,  0,0,32'h0,         0,0,32'h0,  32'h0,        32'h0, 0,0,0,2'd0);
        tbl[1]  = v(0,0,0,32'h0,  1,0,32'h0,         1,1,32'h0,  32'h0,        32'h0, 1,0,0,2'd0);
        tbl[2]  = v(0,0,0,32'h0,  0,1,32'h2001_0005, 1,0,32'h4,  32'h0,        32'h0, 1,0,0,2'd1);
        tbl[3]  = v(0,0,0,32'h0,  1,0,32'h0,         1,1,32'h4,  32'h2001_0005,32'h4, 0,0,1,2'd0);
        tbl[4]  = v(0,0,0,32'h0,  0,1,32'h2002_0007, 1,0,32'h8,  32'h2001_0005,32'h4, 1,0,0,2'd1);
        tbl[5]  = v(0,1,0,32'h0,  1,0,32'h0,         1,0,32'h8,  32'h2002_0007,32'h8, 0,1,1,2'd0);
        tbl[6]  = v(0,1,0,32'h0,  1,0,32'h0,         1,0,32'h8,  32'h2002_0007,32'h8, 0,1,1,2'd0);
        tbl[7]  = v(0,1,0,32'h0,  1,0,32'h0,         1,0,32'h8,  32'h2002_0007,32'h8, 0,1,1,2'd0);
        tbl[8]  = v(0,0,0,32'h0,  0,0,32'h0,         1,1,32'h8,  32'h2002_0007,32'h8, 0,0,1,2'd0);
        tbl[9]  = v(0,0,0,32'h0,  1,0,32'h0,         1,1,32'h8,  32'h2002_0007,32'h8, 1,0,0,2'd0);
        tbl[10] = v(0,0,1,32'h43, 0,0,32'h0,         1,0,32'hC,  32'h2002_0007,32'h8, 1,0,0,2'd1);
        tbl[11] = v(0,0,0,32'h0,  0,1,32'hDEAD_BEEF, 1,0,32'h40, 32'h2002_0007,32'h8, 1,0,0,2'd2);
        tbl[12] = v(0,0,0,32'h0,  1,0,32'h0,         1,1,32'h40, 32'h2002_0007,32'h8, 1,0,0,2'd0);
        tbl[13] = v(0,0,0,32'h0,  0,1,32'h1111_1111, 1,0,32'h44, 32'h2002_0007,32'h8, 1,0,0,2'd1);
        tbl[14] = v(0,1,1,32'h100,1,0,32'h0,         1,0,32'h44, 32'h1111_1111,32'h44,1,0,1,2'd0);
        tbl[15] = v(0,1,0,32'h0,  0,0,32'h0,         1,1,32'h100,32'h1111_1111,32'h44,0,1,0,2'd0);
        tbl[16] = v(0,0,0,32'h0,  1,0,32'h0,         1,1,32'h100,32'h1111_1111,32'h44,1,0,0,2'd0);
        tbl[17] = v(1,0,0,32'h0,  0,1,32'h55,        1,0,32'h104,32'h1111_1111,32'h44,1,0,0,2'd1);
        tbl[18] = v(0,0,0,32'h0,  0,0,32'h0,         1,1,32'h0,  32'h0,        32'h0, 1,0,0,2'd0);

        apply(1, 0, 0, 32'h0, 0, 0, 32'h0);
        @(posedge clk); #1;

        for (int i = 0; i < 19; i++) begin
            apply(tbl[i].rst, tbl[i].stall, tbl[i].rdir, tbl[i].rpc, tbl[i].ack, tbl[i].rv, tbl[i].rdata);
            @(negedge clk);
            if (tbl[i].chk) begin
                check($sformatf("vec%0d req", i),    {31'h0, req},    {31'h0, tbl[i].req});
                check($sformatf("vec%0d addr", i),   addr,            tbl[i].addr);
                check($sformatf("vec%0d inst", i),   inst,            tbl[i].inst);
                check($sformatf("vec%0d pc4", i),    pc4,             tbl[i].pc4);
                check($sformatf("vec%0d flush", i),  {31'h0, flush},  {31'h0, tbl[i].flush});
                check($sformatf("vec%0d istall", i), {31'h0, istall}, {31'h0, tbl[i].istall});
                check($sformatf("vec%0d bufv", i),   {31'h0, bv},     {31'h0, tbl[i].bv});
                check($sformatf("vec%0d state", i),  {30'h0, st},     {30'h0, tbl[i].st});
            end
            @(posedge clk); #1;
        end

        // Reset vector at the top of the address space wraps on the first increment.
        apply(1, 0, 0, 32'h0, 0, 0, 32'h0);
        @(posedge clk); #1;
        apply(0, 0, 0, 32'h0, 1, 0, 32'h0);
        @(negedge clk);
        check("wrap first addr", addr2, 32'hFFFF_FFFC);
        check("wrap first req", {31'h0, req2}, 32'h1);
        @(posedge clk); #1;
        apply(0, 0, 0, 32'h0, 0, 1, 32'h1234_5678);
        @(negedge clk);
        check("wrap next addr", addr2, 32'h0);
        @(posedge clk); #1;
        apply(0, 1, 0, 32'h0, 0, 0, 32'h0);
        @(negedge clk);
        check("wrap pc4", pc42, 32'h0);
        check("wrap inst", inst2, 32'h1234_5678);
        check("wrap bufv", {31'h0, bv2}, 32'h1);
        @(posedge clk); #1;

        // Randomized run with a variable-latency memory responder.
        apply(1, 0, 0, 32'h0, 0, 0, 32'h0);
        @(posedge clk); #1;
        model_reset(32'h0);
        mem_pend = 0; mem_cnt = 0; mem_data = 32'h0;
        for (int c = 0; c < 800; c++) begin
            r  = ($urandom_range(0, 149) == 0);
            s  = ($urandom_range(0, 3) == 0);
            d  = ($urandom_range(0, 6) == 0);
            p  = $urandom;
            a  = ($urandom_range(0, 2) != 0);
            if (mem_pend && mem_cnt == 0) begin
                vl = 1; dt = mem_data;
            end else begin
                vl = 0; dt = $urandom;
            end
            apply(r, s, d, p, a, vl, dt);
            @(negedge clk);
            model_outputs(s, d);
            check("rnd req", {31'h0, req}, {31'h0, e_req});
            check("rnd addr", addr, m_pc);
            check("rnd inst", inst, m_inst);
            check("rnd pc4", pc4, m_pc4);
            check("rnd flush", {31'h0, flush}, {31'h0, e_flush});
            check("rnd istall", {31'h0, istall}, {31'h0, e_istall});
            check("rnd bufv", {31'h0, bv}, {31'h0, m_full});
            req_seen = req;
            @(posedge clk); #1;
            model_edge(r, s, d, p, a, vl, dt);
            if (r || vl) begin
                mem_pend = 0;
            end else if (mem_pend) begin
                mem_cnt--;
            end
            if (!r && req_seen && a) begin
                mem_pend = 1;
                mem_cnt  = $urandom_range(0, 2);
                mem_data = $urandom;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
